serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 13 +
 rtl/serial_adder_add_chunk.sv | 26 ++
 rtl/serial_adder.sv | 110 +++++++++++
 tb/tb_serial_adder.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and default sizing for the chunked serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

endpackage

// File: rtl/serial_adder_add_chunk.sv
// Combinational CHUNK-bit ripple-carry adder slice used once per clock by serial_adder.
module add_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  logic [CHUNK:0] c;

  // NOTE: combinational logic uses blocking '=' so each bit sees the carry computed just above it.
  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < CHUNK; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[CHUNK];
  end

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: WIDTH-bit a+b+cin computed CHUNK bits per clock with a registered inter-chunk carry.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N) + 1;

  if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_adder: WIDTH must be a positive multiple of CHUNK");
  end

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             carry_q, cout_q;
  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             accept, last;

  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CW'(N - 1));

  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a  (a_q[int'(cnt)*CHUNK +: CHUNK]),
    .b  (b_q[int'(cnt)*CHUNK +: CHUNK]),
    .ci (carry_q),
    .s  (chunk_s),
    .co (chunk_co)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // NOTE: state_nx gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: operand registers carry no reset; they are always loaded before being used.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      cnt     <= '0;
      sum_q   <= '0;
      carry_q <= cin;
      cout_q  <= 1'b0;
    end else if (state == RUN) begin
      sum_q[int'(cnt)*CHUNK +: CHUNK] <= chunk_s;
      carry_q <= chunk_co;
      cnt     <= cnt + 1'b1;
      if (last) cout_q <= chunk_co;
    end
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic ovf_q;

  // The final chunk's top bit is the sum MSB, so overflow is settled on the last edge.
  always_ff @(posedge clk) begin
    if (rst || accept) ovf_q <= 1'b0;
    else if (last)     ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (chunk_s[CHUNK-1] != a_q[WIDTH-1]);
  end

  assign ovf = ovf_q;
`endif

  assign busy = (state == RUN);
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder (16/4 and 16/16 builds) against an arithmetic model.
module tb_serial_adder;

  localparam int W = 16;
  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst, start, start_w, cin;
  logic [W-1:0]  a, b;
  logic          busy, done, cout, busy_w, done_w, cout_w;
  logic [W-1:0]  sum, sum_w;
`ifdef SERIAL_ADDER_OVF_EN
  logic          ovf, ovf_w;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf),
`endif
    .cout(cout)
  );

  serial_adder #(.WIDTH(W), .CHUNK(W)) dut_w (
    .clk(clk), .rst(rst), .start(start_w), .a(a), .b(b), .cin(cin),
    .busy(busy_w), .done(done_w), .sum(sum_w),
`ifdef SERIAL_ADDER_OVF_EN
    .ovf(ovf_w),
`endif
    .cout(cout_w)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: full-precision arithmetic gives {cout, sum}; overflow from operand/result signs.
  task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input string tag);
    logic [W:0] ref_v;
    int         edges;
    ref_v = {1'b0, ta} + {1'b0, tb} + (W+1)'(tc);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk); #1;
    check({tag, ":busy_on_accept"}, 32'(busy), 32'(1));
    check({tag, ":sum_cleared"}, 32'(sum), 32'(0));
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    edges = 0;
    while (!done && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check({tag, ":latency"}, 32'(edges), 32'(N));
    check({tag, ":sum"}, 32'(sum), 32'(ref_v[W-1:0]));
    check({tag, ":cout"}, 32'(cout), 32'(ref_v[W]));
    check({tag, ":busy_at_done"}, 32'(busy), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    check({tag, ":ovf"}, 32'(ovf),
          32'((ta[W-1] == tb[W-1]) && (ref_v[W-1] != ta[W-1])));
`endif
    @(posedge clk); #1;
    check({tag, ":done_one_cycle"}, 32'(done), 32'(0));
    check({tag, ":sum_held"}, 32'(sum), 32'(ref_v[W-1:0]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int last_done, pulses, gap_bad;
    rst = 1'b1; start = 1'b0; start_w = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset:busy", 32'(busy), 32'(0));
    check("reset:done", 32'(done), 32'(0));
    check("reset:sum", 32'(sum), 32'(0));
    check("reset:cout", 32'(cout), 32'(0));

    // Reset wins over start on the same edge.
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1;
    check("rst_prio:busy", 32'(busy), 32'(0));
    @(negedge clk); rst = 1'b0; start = 1'b0;

    run_add(16'h1234, 16'h4321, 1'b0, "d_5555");
    run_add(16'hFFFF, 16'h0001, 1'b0, "d_wrap");
    run_add(16'h7FFF, 16'h0001, 1'b0, "d_ovf");
    run_add(16'h8000, 16'h8000, 1'b1, "d_negovf");
    for (int i = 0; i < 40; i++) run_add(W'($urandom), W'($urandom), 1'($urandom), "rand");

    // Reset on the second RUN edge discards the addition.
    @(negedge clk); start = 1'b1; a = 16'h1111; b = 16'h2222; cin = 1'b0;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midrst:busy", 32'(busy), 32'(0));
    check("midrst:done", 32'(done), 32'(0));
    check("midrst:sum", 32'(sum), 32'(0));
    check("midrst:cout", 32'(cout), 32'(0));
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    check("midrst:no_done", 32'(pulses), 32'(0));

    // start held high: a new addition every N+1 cycles with no gap.
    @(negedge clk); start = 1'b1; a = 16'h000F; b = 16'h0001; cin = 1'b1;
    last_done = -1; pulses = 0; gap_bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done) begin
        check("b2b:sum", 32'(sum), 32'h0011);
        if (last_done >= 0) check("b2b:period", 32'(i - last_done), 32'(N + 1));
        last_done = i;
        pulses++;
      end
    end
    check("b2b:pulses", 32'(pulses), 32'(6));
    @(negedge clk); start = 1'b0;
    repeat (N + 2) @(posedge clk);

    // CHUNK == WIDTH: single-edge addition.
    @(negedge clk); start_w = 1'b1; a = 16'h8000; b = 16'h8000; cin = 1'b1;
    @(posedge clk); #1;
    start_w = 1'b0;
    check("wide:busy", 32'(busy_w), 32'(1));
    @(posedge clk); #1;
    check("wide:done", 32'(done_w), 32'(1));
    check("wide:sum", 32'(sum_w), 32'h0001);
    check("wide:cout", 32'(cout_w), 32'(1));
`ifdef SERIAL_ADDER_OVF_EN
    check("wide:ovf", 32'(ovf_w), 32'(1));
`endif
    @(posedge clk); #1;
    check("wide:done_off", 32'(done_w), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
